// File: rtl/down_counter_nbit.sv
// Loadable N-bit down-counter with start/busy/done handshake, optional auto-reload on terminal
// count and a combinational borrow flag.
module down_counter_nbit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clkEN,
    input  logic             start,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             cnt,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             bo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01
    } state_e;

    localparam logic [WIDTH-1:0] CountZero = '0;
    localparam logic [WIDTH-1:0] CountOne  = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             ld_zero;

    assign ld_zero = (ld_val == CountZero);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= CountZero;
            done_q  <= 1'b0;
        end else if (clkEN) begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    count_d = ld_val;
                    if (ld_zero) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (start) begin
                    // Restart: a zero reload value is a zero-length countdown.
                    count_d = ld_val;
                    if (ld_zero) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else if (cnt) begin
                    if (count_q == CountOne) begin
                        done_d = 1'b1;
                        if (auto_reload && !ld_zero) begin
                            count_d = ld_val;
                        end else begin
                            count_d = CountZero;
                            state_d = StIdle;
                        end
                    end else if (count_q != CountZero) begin
                        count_d = count_q - CountOne;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        count = count_q;
        done  = done_q;
        busy  = (state_q == StRun);
        bo    = (count_q == CountZero);
    end

endmodule
